uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Round-robin scheduler that shares the single UART transmit path among `N_REQ` requesters (ALU result, register-file read, status). Each requester posts a 1- or 2-byte word. The block grants one requester at a time and serialises its bytes into the UART TX parallel interface, handshaking on the transmitter's `busy` flag. A stalled transmitter is reported through a timeout pulse.

## Interface
- `N_REQ`, default 2: number of requesters, 2..8.
- `BUSY_TO`, default 4: cycles allowed between `tx_d_vld` and `tx_busy` rising.

- `CLK`  in  1  system clock.
- `RST`  in  1  synchronous, active-high reset.
- `sched_en`  in  1  when low, no new grants are issued; a frame in progress completes.
- `req_valid`  in  `N_REQ`  per-requester request; held until the matching `req_ack`.
- `req_data`  in  `16*N_REQ`  word for requester i at `[16*i +: 16]`.
- `req_two`  in  `N_REQ`  1 sends 2 bytes, 0 sends 1 byte.
- `req_ack`  out  `N_REQ`  one-cycle pulse when the word has been latched.
- `tx_p_data`  out  8  byte to UART TX.
- `tx_d_vld`  out  1  one-cycle data-valid to UART TX.
- `tx_busy`  in  1  UART TX busy, synchronous to `CLK`.
- `sched_busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse after the last byte completes.
- `tx_timeout`  out  1  one-cycle pulse when a transfer is aborted.

## Operation
- All outputs are registered. Reset value of every output is 0. State resets to IDLE and the round-robin pointer to 0.
- **IDLE**
  - Condition: `sched_en` and any `req_valid`.
  - Grant g is the first set bit at or after the pointer, searching cyclically.
  - Latch `req_data[g]` and `req_two[g]`; set `byte_idx` = 0.
  - Pulse `req_ack[g]`, then go to ISSUE.
- **ISSUE**
  - If `tx_busy` = 0: drive `tx_p_data` = selected byte and pulse `tx_d_vld`; clear the timeout counter; go to WAIT_HI.
  - If `tx_busy` = 1: hold in ISSUE.
- **WAIT_HI**
  - On `tx_busy` = 1: go to WAIT_LO.
  - Otherwise count. When the count reaches `BUSY_TO`: pulse `tx_timeout`, set pointer = g+1 mod `N_REQ`, go to IDLE. No `frame_done` is issued.
- **WAIT_LO**
  - On `tx_busy` = 0:
    - If `req_two` and `byte_idx` = 0: set `byte_idx` = 1, go to ISSUE.
    - Otherwise: pulse `frame_done`, set pointer = g+1 mod `N_REQ`, go to IDLE.
- Byte order: `[7:0]` first, then `[15:8]`.
- `tx_p_data` holds its value outside `tx_d_vld` cycles.
- Any `req_valid` seen while not in IDLE is not acknowledged; requesters keep it asserted.

## Timing
- Request to `req_ack`: request sampled at edge k, `req_ack` high in cycle k+1 for one cycle.
- The requester must drop or replace `req_valid` the cycle after `req_ack`, otherwise it is re-granted.
- `req_ack` to first `tx_d_vld`: 1 cycle minimum; more if `tx_busy` is high.
- `tx_busy` normally rises the cycle after `tx_d_vld`.
- Back-to-back frames: `frame_done` cycle, IDLE for one cycle, next `req_ack`. This gives a minimum 1-cycle gap between frames.
- Simultaneous requests: the pointer decides. After g is served, g has the lowest priority.
- `sched_en` falling mid-frame: the frame completes, then the block stays in IDLE.
- `RST` mid-frame: next edge gives IDLE with all outputs 0. A UART frame already started by the transmitter is not aborted.
- Timeout counter width is $clog2(`BUSY_TO`+1). It never wraps, because it is cleared on every `tx_d_vld`.

## Structure
- Shared package `uart_sched_pkg` holds:
  - the `sched_state_e` enum (IDLE, ISSUE, WAIT_HI, WAIT_LO);
  - `BYTE_W` = 8;
  - `WORD_W` = 16.
- One sub-module, `rr_arbiter`: combinational grant from `req_valid` and pointer, one-hot output. The pointer register lives in `uart_tx_sched`.

## Test plan
- **Single 1-byte request:** req0, data 0x00A5, two=0 → `req_ack[0]`, one `tx_d_vld` with 0xA5, `frame_done` after `tx_busy` falls, pointer = 1.
- **Single 2-byte request:** req1, data 0x1234, two=1 → `tx_p_data` 0x34 then 0x12, each a single `tx_d_vld`, exactly one `frame_done`.
- **Contention with N_REQ=2:** both requests held high, each posting one byte (0x11 / 0x22) → grants alternate 0,1,0,1 and bytes alternate 0x11, 0x22.
- **Transmitter stall:** `tx_busy` held 0 after `tx_d_vld` → `tx_timeout` exactly `BUSY_TO` cycles later, no `frame_done`, returns to IDLE, next grant goes to the other requester.
- **Gating and reset:**
  - `sched_en` = 0 with a request pending → no `req_ack`.
  - `sched_en` dropped during a 2-byte frame → both bytes sent, then no further grants.
  - `RST` pulsed in WAIT_LO → all outputs 0 on the next cycle.
- **Busy at grant:** `tx_busy` = 1 when entering ISSUE → `tx_d_vld` held off until the cycle after `tx_busy` falls.

Source files
------------

// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg: shared widths and scheduler state encoding for uart_tx_sched.
package uart_sched_pkg;
    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO} sched_state_e;
endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant, first request at or after a one-hot pointer.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] ptr,
    output logic [N-1:0] gnt
);
    logic [N-1:0] masked;
    logic [N-1:0] pick;
    always_comb begin
        // bits at or above the pointer win; otherwise wrap to the lowest request
        masked = req & ~(ptr - N'(1));
        pick   = (|masked) ? masked : req;
        gnt    = pick & (~pick + N'(1));
    end
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler serialising 1/2-byte words onto a UART TX port.
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int BUSY_TO = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    sched_en,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [WORD_W*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]        req_two,
    output logic [N_REQ-1:0]        req_ack,
    output logic [BYTE_W-1:0]       tx_p_data,
    output logic                    tx_d_vld,
    input  logic                    tx_busy,
    output logic                    sched_busy,
    output logic                    frame_done,
    output logic                    tx_timeout
);
    localparam int CNT_W = $clog2(BUSY_TO + 1);

    sched_state_e              state_q, state_d;
    logic [N_REQ-1:0]          ptr_q, ptr_d;
    logic [N_REQ-1:0]          grant_q, grant_d;
    logic [WORD_W-1:0]         data_q, data_d;
    logic                      two_q, two_d;
    logic                      byte_idx_q, byte_idx_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [N_REQ-1:0]          req_ack_q, req_ack_d;
    logic [BYTE_W-1:0]         tx_p_data_q, tx_p_data_d;
    logic                      tx_d_vld_q, tx_d_vld_d;
    logic                      sched_busy_q, sched_busy_d;
    logic                      frame_done_q, frame_done_d;
    logic                      tx_timeout_q, tx_timeout_d;
    logic [N_REQ-1:0]          gnt;
    logic [N_REQ-1:0]          ptr_next;
    logic [N_REQ:0][WORD_W-1:0] acc;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (gnt)
    );

    // one-hot mux of the granted word
    assign acc[0] = '0;
    for (genvar i = 0; i < N_REQ; i++) begin : g_sel
        assign acc[i+1] = acc[i] | ({WORD_W{gnt[i]}} & req_data[WORD_W*i +: WORD_W]);
    end

    // pointer is kept one-hot; g+1 mod N_REQ is a left rotate of the grant
    assign ptr_next = {grant_q[N_REQ-2:0], grant_q[N_REQ-1]};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            ptr_q        <= N_REQ'(1);
            grant_q      <= '0;
            data_q       <= '0;
            two_q        <= 1'b0;
            byte_idx_q   <= 1'b0;
            cnt_q        <= '0;
            req_ack_q    <= '0;
            tx_p_data_q  <= '0;
            tx_d_vld_q   <= 1'b0;
            sched_busy_q <= 1'b0;
            frame_done_q <= 1'b0;
            tx_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            grant_q      <= grant_d;
            data_q       <= data_d;
            two_q        <= two_d;
            byte_idx_q   <= byte_idx_d;
            cnt_q        <= cnt_d;
            req_ack_q    <= req_ack_d;
            tx_p_data_q  <= tx_p_data_d;
            tx_d_vld_q   <= tx_d_vld_d;
            sched_busy_q <= sched_busy_d;
            frame_done_q <= frame_done_d;
            tx_timeout_q <= tx_timeout_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        grant_d      = grant_q;
        data_d       = data_q;
        two_d        = two_q;
        byte_idx_d   = byte_idx_q;
        cnt_d        = cnt_q;
        req_ack_d    = '0;
        tx_p_data_d  = tx_p_data_q;
        tx_d_vld_d   = 1'b0;
        frame_done_d = 1'b0;
        tx_timeout_d = 1'b0;
        case (state_q)
            IDLE: if (sched_en && |req_valid) begin
                state_d    = ISSUE;
                grant_d    = gnt;
                data_d     = acc[N_REQ];
                two_d      = |(gnt & req_two);
                byte_idx_d = 1'b0;
                req_ack_d  = gnt;
            end
            ISSUE: if (!tx_busy) begin
                tx_p_data_d = byte_idx_q ? data_q[WORD_W-1:BYTE_W] : data_q[BYTE_W-1:0];
                tx_d_vld_d  = 1'b1;
                cnt_d       = '0;
                state_d     = WAIT_HI;
            end
            WAIT_HI: if (tx_busy) begin
                state_d = WAIT_LO;
            end else if (cnt_q + CNT_W'(1) == CNT_W'(BUSY_TO)) begin
                tx_timeout_d = 1'b1;
                ptr_d        = ptr_next;
                state_d      = IDLE;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            WAIT_LO: if (!tx_busy) begin
                if (two_q && !byte_idx_q) begin
                    byte_idx_d = 1'b1;
                    state_d    = ISSUE;
                end else begin
                    frame_done_d = 1'b1;
                    ptr_d        = ptr_next;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        sched_busy_d = state_d != IDLE;
    end

    assign req_ack    = req_ack_q;
    assign tx_p_data  = tx_p_data_q;
    assign tx_d_vld   = tx_d_vld_q;
    assign sched_busy = sched_busy_q;
    assign frame_done = frame_done_q;
    assign tx_timeout = tx_timeout_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed bench for uart_tx_sched with a small UART TX busy model.
module tb_uart_tx_sched;
    localparam int N  = 2;
    localparam int TO = 4;
    localparam int W_ACK = 0, W_BYTE = 1, W_DONE = 2, W_TO = 3;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         sched_en = 1'b0;
    logic [N-1:0] req_valid = '0;
    logic [N-1:0] req_two = '0;
    logic [31:0]  req_data = '0;
    logic [N-1:0] req_ack;
    logic [7:0]   tx_p_data;
    logic         tx_d_vld, tx_busy, sched_busy, frame_done, tx_timeout;

    bit force_busy, stall, mb, pend;
    int left;
    int n_chk, n_bad, cyc, n_acks, n_bytes, n_done, n_to, done_cyc, to_cyc;
    logic [7:0] byte_log [64];
    int         byte_cyc [64];
    logic [1:0] ack_log  [64];
    int         ack_cyc  [64];

    uart_tx_sched #(.N_REQ(N), .BUSY_TO(TO)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .sched_en   (sched_en),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_two    (req_two),
        .req_ack    (req_ack),
        .tx_p_data  (tx_p_data),
        .tx_d_vld   (tx_d_vld),
        .tx_busy    (tx_busy),
        .sched_busy (sched_busy),
        .frame_done (frame_done),
        .tx_timeout (tx_timeout)
    );

    always #5 CLK = ~CLK;

    assign tx_busy = force_busy | mb;

    // transmitter: busy rises the cycle after tx_d_vld and stays up for three cycles
    always @(negedge CLK) begin
        if (pend) begin
            mb = 1'b1;
            left = 3;
            pend = 1'b0;
        end else if (left > 0) begin
            left--;
            if (left == 0) mb = 1'b0;
        end
        if (tx_d_vld && !stall) pend = 1'b1;
    end

    always begin
        @(posedge CLK);
        #1;
        cyc++;
        if (tx_d_vld) begin
            byte_log[n_bytes] = tx_p_data;
            byte_cyc[n_bytes] = cyc;
            n_bytes++;
        end
        if (|req_ack) begin
            ack_log[n_acks] = req_ack;
            ack_cyc[n_acks] = cyc;
            n_acks++;
        end
        if (frame_done) begin
            done_cyc = cyc;
            n_done++;
        end
        if (tx_timeout) begin
            to_cyc = cyc;
            n_to++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    function automatic int cnt_of(input int w);
        case (w)
            W_ACK:   return n_acks;
            W_BYTE:  return n_bytes;
            W_DONE:  return n_done;
            default: return n_to;
        endcase
    endfunction

    task automatic wait_cnt(input string tag, input int w, input int target);
        int t;
        t = 0;
        while (cnt_of(w) < target && t < 200) begin
            @(negedge CLK);
            t++;
        end
        check({tag, "_wait"}, 32'(t < 200), 1);
    endtask

    initial begin
        int a, b, d, e, rc;
        tick(3);
        check("rst_ack", 32'(req_ack), 0);
        check("rst_vld", 32'(tx_d_vld), 0);
        check("rst_data", 32'(tx_p_data), 0);
        check("rst_busy", 32'(sched_busy), 0);
        check("rst_done", 32'(frame_done), 0);
        check("rst_to", 32'(tx_timeout), 0);
        RST = 1'b0;
        tick(1);

        // single 1-byte request from requester 0
        a = n_acks; b = n_bytes; d = n_done; rc = cyc;
        sched_en = 1'b1; req_data = 32'h0000_00A5; req_two = 2'b00; req_valid = 2'b01;
        wait_cnt("t1_ack", W_ACK, a + 1);
        req_valid = 2'b00;
        check("t1_ack", 32'(ack_log[a]), 2'b01);
        check("t1_ack_lat", ack_cyc[a] - rc, 1);
        wait_cnt("t1_done", W_DONE, d + 1);
        check("t1_nbytes", n_bytes - b, 1);
        check("t1_byte", 32'(byte_log[b]), 8'hA5);
        check("t1_vld_lat", byte_cyc[b] - ack_cyc[a], 1);
        check("t1_hold", 32'(tx_p_data), 8'hA5);
        check("t1_idle", 32'(sched_busy), 0);

        // both post; pointer is now 1 so requester 1 wins with a 2-byte word
        a = n_acks; b = n_bytes; d = n_done;
        req_data = 32'h1234_0077; req_two = 2'b10; req_valid = 2'b11;
        wait_cnt("t2_ack", W_ACK, a + 1);
        req_valid = 2'b00;
        check("t2_ack", 32'(ack_log[a]), 2'b10);
        wait_cnt("t2_done", W_DONE, d + 1);
        tick(3);
        check("t2_nbytes", n_bytes - b, 2);
        check("t2_lo", 32'(byte_log[b]), 8'h34);
        check("t2_hi", 32'(byte_log[b+1]), 8'h12);
        check("t2_ndone", n_done - d, 1);
        check("t2_nack", n_acks - a, 1);

        // contention: both held high, grants alternate
        a = n_acks; b = n_bytes; d = n_done;
        req_data = 32'h0022_0011; req_two = 2'b00; req_valid = 2'b11;
        wait_cnt("t3_ack", W_ACK, a + 4);
        req_valid = 2'b00;
        wait_cnt("t3_done", W_DONE, d + 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_ack%0d", i), 32'(ack_log[a+i]), (i % 2 == 0) ? 2'b01 : 2'b10);
            check($sformatf("t3_byte%0d", i), 32'(byte_log[b+i]), (i % 2 == 0) ? 8'h11 : 8'h22);
        end

        // transmitter stall on requester 0 -> timeout, then requester 1 is next
        a = n_acks; b = n_bytes; d = n_done; e = n_to;
        stall = 1'b1; req_data = 32'h0066_0055; req_valid = 2'b01;
        wait_cnt("t4_ack", W_ACK, a + 1);
        req_valid = 2'b00;
        wait_cnt("t4_to", W_TO, e + 1);
        check("t4_to_lat", to_cyc - byte_cyc[b], TO);
        check("t4_nodone", n_done - d, 0);
        check("t4_idle", 32'(sched_busy), 0);
        check("t4_to_pulse", 32'(tx_timeout), 1);
        stall = 1'b0;
        a = n_acks; b = n_bytes; d = n_done;
        req_valid = 2'b11;
        wait_cnt("t4_ack2", W_ACK, a + 1);
        req_valid = 2'b00;
        check("t4_ack2", 32'(ack_log[a]), 2'b10);
        wait_cnt("t4_done", W_DONE, d + 1);
        check("t4_byte", 32'(byte_log[b]), 8'h66);
        check("t4_nto", n_to - e, 1);

        // gating: nothing granted while sched_en is low
        a = n_acks; b = n_bytes; d = n_done;
        sched_en = 1'b0; req_data = 32'h0000_BEEF; req_two = 2'b01; req_valid = 2'b01;
        tick(6);
        check("t5_gated", n_acks - a, 0);
        check("t5_gated_busy", 32'(sched_busy), 0);
        sched_en = 1'b1;
        wait_cnt("t5_ack", W_ACK, a + 1);
        check("t5_ack", 32'(ack_log[a]), 2'b01);
        // drop enable mid-frame with requester 1 pending
        sched_en = 1'b0; req_valid = 2'b10;
        wait_cnt("t5_done", W_DONE, d + 1);
        check("t5_lo", 32'(byte_log[b]), 8'hEF);
        check("t5_hi", 32'(byte_log[b+1]), 8'hBE);
        tick(6);
        check("t5_nogrant", n_acks - a, 1);
        check("t5_stay_idle", 32'(sched_busy), 0);

        // reset while in WAIT_LO
        a = n_acks; b = n_bytes; d = n_done;
        req_data = 32'h00C3_0000; req_two = 2'b00; sched_en = 1'b1;
        wait_cnt("t6_ack", W_ACK, a + 1);
        req_valid = 2'b00;
        wait_cnt("t6_byte", W_BYTE, b + 1);
        tick(2);
        check("t6_in_frame", 32'(sched_busy), 1);
        RST = 1'b1;
        tick(1);
        check("t6_ack", 32'(req_ack), 0);
        check("t6_vld", 32'(tx_d_vld), 0);
        check("t6_data", 32'(tx_p_data), 0);
        check("t6_busy", 32'(sched_busy), 0);
        check("t6_done", 32'(frame_done), 0);
        check("t6_to", 32'(tx_timeout), 0);
        RST = 1'b0;
        tick(6);
        check("t6_nodone", n_done - d, 0);

        // transmitter busy when the grant lands in ISSUE
        a = n_acks; b = n_bytes; d = n_done;
        force_busy = 1'b1; req_data = 32'h0000_005A; req_valid = 2'b01;
        wait_cnt("t7_ack", W_ACK, a + 1);
        req_valid = 2'b00;
        check("t7_ack", 32'(ack_log[a]), 2'b01);
        tick(3);
        check("t7_held", n_bytes - b, 0);
        rc = cyc;
        force_busy = 1'b0;
        wait_cnt("t7_byte", W_BYTE, b + 1);
        check("t7_vld_lat", byte_cyc[b] - rc, 1);
        check("t7_data", 32'(byte_log[b]), 8'h5A);
        wait_cnt("t7_done", W_DONE, d + 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
